// File: rtl/data_mem_wait.sv
// data_mem_wait: word-organised data memory with a fixed access latency.
// A request taken in IDLE is latched, busy stays high for LATENCY cycles,
// and the access commits on the last busy edge. The following DONE cycle
// presents ReadData to the write-back path with busy low.
//
// Handshake: req = MemRead | MemWrite is a level held by the controller.
// A request is accepted only in IDLE, and busy rises in the same cycle.
// The controller must hold the request while busy is high. It completes
// the instruction in the first busy-low cycle (DONE), where any request
// still present is treated as the same access and is not re-issued.
module data_mem_wait #(
  parameter int NBITS     = 8,
  parameter int ADDR_BITS = 5,
  parameter int LATENCY   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [NBITS-1:0] ReadData,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   is_wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [NBITS-1:0]       wdata_q;
  logic [NBITS-1:0]       rdata_q;
  logic [NBITS-1:0]       mem_q [DEPTH];

  logic                   req;
  logic [ADDR_BITS-1:0]   in_idx;
  logic                   start;
  logic                   fin_wait;
  logic                   fin_now;
  logic                   commit;
  logic                   cm_wr;
  logic [ADDR_BITS-1:0]   cm_idx;
  logic [NBITS-1:0]       cm_data;
  logic                   unused_addr_bits;

  // Byte offset and bits above the word index are ignored, so addresses alias.
  assign req              = MemRead | MemWrite;
  assign in_idx           = Address[ADDR_BITS+1:2];
  assign unused_addr_bits = ^Address;

  // An access finishes either at the end of its last WAIT cycle, or, with a
  // single-cycle latency, on the very edge that accepts it. In the latter
  // case the live inputs are the operands since nothing is latched yet.
  assign start    = (state_q == S_IDLE) && req;
  assign fin_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);
  assign fin_now  = start && (LATENCY == 1);
  assign commit   = !reset && (fin_wait || fin_now);
  assign cm_wr    = fin_now ? MemWrite  : is_wr_q;
  assign cm_idx   = fin_now ? in_idx    : idx_q;
  assign cm_data  = fin_now ? WriteData : wdata_q;

  assign busy      = start || (state_q == S_WAIT);
  assign ReadData  = rdata_q;
  assign dbg_state = state_q;

  // Controller FSM: latch the request, count out the latency, load read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            is_wr_q <= MemWrite;
            idx_q   <= in_idx;
            wdata_q <= WriteData;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY > 1) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (commit && !cm_wr) rdata_q <= mem_q[cm_idx];
    end
  end

  // Storage array: not reset; a write squashed by reset never lands.
  always_ff @(posedge clock) begin
    if (commit && cm_wr) mem_q[cm_idx] <= cm_data;
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// tb_data_mem_wait: directed bench for data_mem_wait (LATENCY=2, ADDR_BITS=5,
// NBITS=8). The driver issues accesses and pushes the ReadData expected in
// the DONE cycle; a monitor pops and compares on each busy falling edge.
module tb_data_mem_wait;

  localparam int LAT = 2;

  logic       clock;
  logic       reset;
  logic [7:0] Address;
  logic [7:0] WriteData;
  logic       MemWrite;
  logic       MemRead;
  logic [7:0] ReadData;
  logic       busy;
  logic [1:0] dbg_state;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  data_mem_wait #(.NBITS(8), .ADDR_BITS(5), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One access: request held for LAT busy cycles, dropped in the DONE cycle.
  // With disturb set, address/data are changed while the access is in flight.
  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] exp_rd,
                        input bit disturb);
    @(posedge clock); #1;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = data;
    exp_q.push_back(exp_rd);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clock);
      check("busy_during_access", {7'd0, busy}, 8'h01);
      @(posedge clock); #1;
      if (disturb) begin
        Address   = 8'h08;
        WriteData = 8'hFF;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clock);
    check("busy_in_done", {7'd0, busy}, 8'h00);
  endtask

  // Scoreboard monitor: a busy falling edge not caused by reset is a DONE cycle.
  initial begin
    logic       prev_busy;
    logic       prev_reset;
    logic [7:0] e;
    prev_busy  = 1'b0;
    prev_reset = 1'b1;
    forever begin
      @(negedge clock);
      if (prev_busy && !busy && !prev_reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got ReadData=%h expected no completion", ReadData);
        end else begin
          e = exp_q.pop_front();
          check("readdata_done", ReadData, e);
        end
      end
      prev_busy  = busy;
      prev_reset = reset;
    end
  end

  // Stimulus
  initial begin
    logic [5:0] pat;
    reset = 1'b1; Address = 8'h00; WriteData = 8'h00; MemWrite = 1'b0; MemRead = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_readdata", ReadData, 8'h00);

    // 1: write 0x5A to 0x08; ReadData stays at its reset value
    access(1'b0, 1'b1, 8'h08, 8'h5A, 8'h00, 1'b0);
    // 2: read back
    access(1'b1, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0);
    // 3: aliases of word index 2
    access(1'b1, 1'b0, 8'h0B, 8'h00, 8'h5A, 1'b0);
    access(1'b1, 1'b0, 8'h88, 8'h00, 8'h5A, 1'b0);

    // 4: write 0x09 to 0x08 squashed by reset in the WAIT cycle
    @(posedge clock); #1;
    MemWrite = 1'b1; Address = 8'h08; WriteData = 8'h09;
    @(negedge clock);
    check("busy_squash_start", {7'd0, busy}, 8'h01);
    @(posedge clock); #1;
    reset = 1'b1; MemWrite = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("busy_after_reset", {7'd0, busy}, 8'h00);
    check("readdata_after_reset", ReadData, 8'h00);
    access(1'b1, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0);

    // 5: both strobes set is a write; ReadData keeps 0x5A
    access(1'b1, 1'b1, 8'h0C, 8'h33, 8'h5A, 1'b0);
    access(1'b1, 1'b0, 8'h0C, 8'h00, 8'h33, 1'b0);

    // Top word index, and inputs changed mid-access must be ignored
    access(1'b0, 1'b1, 8'h7C, 8'hA5, 8'h33, 1'b0);
    access(1'b0, 1'b1, 8'h10, 8'h11, 8'h33, 1'b1);
    access(1'b1, 1'b0, 8'hFC, 8'h00, 8'hA5, 1'b1);
    access(1'b1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0);
    access(1'b1, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0);

    // 6: MemRead held for 6 cycles gives two accesses, busy 1,1,0,1,1,0
    pat = 6'b011011; // bit i = expected busy in cycle i
    @(posedge clock); #1;
    MemRead = 1'b1; Address = 8'h0C;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h33);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("busy_held_read", {7'd0, busy}, {7'd0, pat[i]});
      if (i < 5) @(posedge clock);
    end
    @(posedge clock); #1;
    MemRead = 1'b0;

    repeat (4) @(posedge clock);
    @(negedge clock);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
